// File: rtl/datapath_control_sequencer_if.sv
// Control/status bundle between the hardwired sequencer and the DataPath.
// The sequencer (master) drives every strobe; the DataPath (slave) returns IR and the condition flag.
interface datapath_control_sequencer_if;
  logic [31:0] ir;
  logic        ConOut;

  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut;
  logic memread, memwrite;
  logic [4:0] ALUCode;

  modport master (
    input  ir, ConOut,
    output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    output HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    output Gra, Grb, Grc, RIn, ROut, BAOut,
    output memread, memwrite, ALUCode
  );

  modport slave (
    output ir, ConOut,
    input  HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    input  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    input  Gra, Grb, Grc, RIn, ROut, BAOut,
    input  memread, memwrite, ALUCode
  );
endinterface

// File: rtl/datapath_control_sequencer.sv
// Hardwired micro-step sequencer: fetch T0-T2, decode IR[31:27] in T3, execute up to T7.
// Strobes are a pure decode of the registered state and the registered/held IR opcode.
module datapath_control_sequencer #(
  parameter logic [4:0] PC_INC_CODE = 5'b11111,
  parameter logic [4:0] ADD_CODE    = 5'b00011,
  parameter int         CNT_W       = 16
) (
  input  logic                         clock,
  input  logic                         clear,
  datapath_control_sequencer_if.master bus,
  output logic                         run,
  output logic                         illegal,
  output logic [CNT_W-1:0]             instr_count
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t           state_q, state_d;
  logic [4:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic [4:0] cur_op;
  logic       is_alu, is_addi, is_muldiv, is_ld, is_st, is_halt, is_short, known;
  logic       retire;

  // IR is already stable during T3; later steps use the copy taken on the T3 edge.
  always_comb begin
    cur_op    = (state_q == S_T3) ? bus.ir[31:27] : op_q;
    is_alu    = (cur_op == OP_ADD) || (cur_op == OP_SUB) ||
                (cur_op == OP_AND) || (cur_op == OP_OR);
    is_addi   = (cur_op == OP_ADDI);
    is_muldiv = (cur_op == OP_MUL) || (cur_op == OP_DIV);
    is_ld     = (cur_op == OP_LD);
    is_st     = (cur_op == OP_ST);
    is_halt   = (cur_op == OP_HALT);
    is_short  = (cur_op == OP_MFHI) || (cur_op == OP_MFLO) || (cur_op == OP_IN) ||
                (cur_op == OP_OUT)  || (cur_op == OP_NOP);
    known     = is_alu || is_addi || is_muldiv || is_ld || is_st || is_halt || is_short;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_halt) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (is_alu || is_addi || is_muldiv || is_ld || is_st) begin
          state_d = S_T4;
        end else begin
          state_d = S_T0;
          retire  = 1'b1;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (is_alu || is_addi) begin
          state_d = S_T0;
          retire  = 1'b1;
        end else begin
          state_d = S_T6;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          state_d = S_T0;
          retire  = 1'b1;
        end else begin
          state_d = S_T7;
        end
      end
      S_T7: begin
        state_d = S_T0;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_RST;
      op_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) begin
        op_q <= bus.ir[31:27];
        if (!known) illegal_q <= 1'b1;
      end
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  logic hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in;
  logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out;
  logic gra, grb, grc, r_in, r_out, ba_out, mem_rd, mem_wr;
  logic [4:0] alu_code;

  always_comb begin
    {hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in} = '0;
    {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out} = '0;
    {gra, grb, grc, r_in, r_out, ba_out, mem_rd, mem_wr} = '0;
    alu_code = '0;
    case (state_q)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu_code = PC_INC_CODE;
      end
      S_T1: begin
        zlo_out = 1'b1; pc_in = 1'b1; mem_rd = 1'b1; mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        if (cur_op == OP_MFHI) begin
          gra = 1'b1; r_in = 1'b1; hi_out = 1'b1;
        end else if (cur_op == OP_MFLO) begin
          gra = 1'b1; r_in = 1'b1; lo_out = 1'b1;
        end else if (cur_op == OP_IN) begin
          iport_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (cur_op == OP_OUT) begin
          gra = 1'b1; r_out = 1'b1; oport_in = 1'b1;
        end else if (is_alu || is_addi) begin
          grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
        end else if (is_muldiv) begin
          gra = 1'b1; r_out = 1'b1; y_in = 1'b1;
        end else if (is_ld || is_st) begin
          grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
        end
      end
      S_T4: begin
        z_in = 1'b1;
        if (is_alu) begin
          grc = 1'b1; r_out = 1'b1; alu_code = cur_op;
        end else if (is_muldiv) begin
          grb = 1'b1; r_out = 1'b1; alu_code = cur_op;
        end else begin
          c_out = 1'b1; alu_code = ADD_CODE;
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (is_muldiv)         lo_in  = 1'b1;
        else if (is_ld || is_st) mar_in = 1'b1;
        else begin
          gra = 1'b1; r_in = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          zhi_out = 1'b1; hi_in = 1'b1;
        end else if (is_ld) begin
          mem_rd = 1'b1; mdr_in = 1'b1;
        end else begin
          // MDR takes its input from the bus when memread is low.
          gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else begin
          mem_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.HiIn     = hi_in;
  assign bus.LoIn     = lo_in;
  assign bus.ZIn      = z_in;
  assign bus.PCIn     = pc_in;
  assign bus.MDRIn    = mdr_in;
  assign bus.MARIn    = mar_in;
  assign bus.YIn      = y_in;
  assign bus.OPortIn  = oport_in;
  assign bus.IRIn     = ir_in;
  assign bus.HiOut    = hi_out;
  assign bus.LoOut    = lo_out;
  assign bus.ZHiOut   = zhi_out;
  assign bus.ZLoOut   = zlo_out;
  assign bus.PCOut    = pc_out;
  assign bus.MDROut   = mdr_out;
  assign bus.IPortOut = iport_out;
  assign bus.COut     = c_out;
  assign bus.Gra      = gra;
  assign bus.Grb      = grb;
  assign bus.Grc      = grc;
  assign bus.RIn      = r_in;
  assign bus.ROut     = r_out;
  assign bus.BAOut    = ba_out;
  assign bus.memread  = mem_rd;
  assign bus.memwrite = mem_wr;
  assign bus.ALUCode  = alu_code;

  assign run         = (state_q != S_RST) && (state_q != S_HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  // The condition flag and IR operand fields are not consumed by this revision.
  logic unused_inputs;
  assign unused_inputs = ^{bus.ConOut, bus.ir[26:0]};

endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Directed bench for the control sequencer: walks each instruction class step by step
// and checks every strobe, ALUCode, run, illegal and instr_count against hand-written values.
module tb_datapath_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run, illegal;
  logic [15:0] instr_count;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  datapath_control_sequencer_if bus ();

  datapath_control_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .bus         (bus),
    .run         (run),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  localparam logic [24:0] M_HIIN     = 25'd1 << 24;
  localparam logic [24:0] M_LOIN     = 25'd1 << 23;
  localparam logic [24:0] M_ZIN      = 25'd1 << 22;
  localparam logic [24:0] M_PCIN     = 25'd1 << 21;
  localparam logic [24:0] M_MDRIN    = 25'd1 << 20;
  localparam logic [24:0] M_MARIN    = 25'd1 << 19;
  localparam logic [24:0] M_YIN      = 25'd1 << 18;
  localparam logic [24:0] M_OPORTIN  = 25'd1 << 17;
  localparam logic [24:0] M_IRIN     = 25'd1 << 16;
  localparam logic [24:0] M_HIOUT    = 25'd1 << 15;
  localparam logic [24:0] M_LOOUT    = 25'd1 << 14;
  localparam logic [24:0] M_ZHIOUT   = 25'd1 << 13;
  localparam logic [24:0] M_ZLOOUT   = 25'd1 << 12;
  localparam logic [24:0] M_PCOUT    = 25'd1 << 11;
  localparam logic [24:0] M_MDROUT   = 25'd1 << 10;
  localparam logic [24:0] M_IPORTOUT = 25'd1 << 9;
  localparam logic [24:0] M_COUT     = 25'd1 << 8;
  localparam logic [24:0] M_GRA      = 25'd1 << 7;
  localparam logic [24:0] M_GRB      = 25'd1 << 6;
  localparam logic [24:0] M_GRC      = 25'd1 << 5;
  localparam logic [24:0] M_RIN      = 25'd1 << 4;
  localparam logic [24:0] M_ROUT     = 25'd1 << 3;
  localparam logic [24:0] M_BAOUT    = 25'd1 << 2;
  localparam logic [24:0] M_MEMRD    = 25'd1 << 1;
  localparam logic [24:0] M_MEMWR    = 25'd1 << 0;

  logic [24:0] strobes;
  assign strobes = {bus.HiIn, bus.LoIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.MARIn, bus.YIn,
                    bus.OPortIn, bus.IRIn, bus.HiOut, bus.LoOut, bus.ZHiOut, bus.ZLoOut,
                    bus.PCOut, bus.MDROut, bus.IPortOut, bus.COut, bus.Gra, bus.Grb,
                    bus.Grc, bus.RIn, bus.ROut, bus.BAOut, bus.memread, bus.memwrite};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [24:0] es, input logic [4:0] ea, input logic er);
    logic [30:0] o, e;
    o = {strobes, bus.ALUCode, run};
    e = {es, ea, er};
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: strobes/alu/run observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_stat(input string tag, input logic exp_ill);
    logic [16:0] o, e;
    o = {instr_count, illegal};
    e = {exp_cnt[15:0], exp_ill};
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: count/illegal observed %h expected %h", tag, o, e);
    end
  endtask

  // Entered in T0; leaves the sequencer in T3.
  task automatic fetch(input string name);
    chk({name, "_T0"}, M_PCOUT | M_MARIN | M_ZIN, 5'b11111, 1'b1);
    tick();
    chk({name, "_T1"}, M_ZLOOUT | M_PCIN | M_MEMRD | M_MDRIN, 5'b0, 1'b1);
    tick();
    chk({name, "_T2"}, M_MDROUT | M_IRIN, 5'b0, 1'b1);
    tick();
  endtask

  function automatic logic [31:0] instr(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  logic [4:0]  sop  [4] = '{5'b11000, 5'b10110, 5'b10111, 5'b11010};
  logic [24:0] smask[4] = '{M_GRA | M_RIN | M_HIOUT, M_IPORTOUT | M_GRA | M_RIN,
                            M_GRA | M_ROUT | M_OPORTIN, 25'd0};

  initial begin
    clear      = 1'b1;
    bus.ir     = instr(5'b11001);
    bus.ConOut = 1'b0;
    tick();
    tick();
    chk("reset_out", 25'd0, 5'd0, 1'b0);
    chk_stat("reset_stat", 1'b0);

    clear = 1'b0;
    tick();
    // mflo
    fetch("mflo");
    chk("mflo_T3", M_GRA | M_RIN | M_LOOUT, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("mflo_retire", 1'b0);

    // mfhi, in, out, nop: one execute step each
    for (int i = 0; i < 4; i++) begin
      bus.ir = instr(sop[i]);
      fetch("short");
      chk("short_T3", smask[i], 5'd0, 1'b1);
      tick();
      exp_cnt++;
    end
    chk_stat("short_retire", 1'b0);

    // add; IR changes after T3 to prove the opcode was latched
    bus.ir = instr(5'b00011);
    fetch("add");
    chk("add_T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    tick();
    bus.ir = instr(5'b11010);
    chk("add_T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1);
    tick();
    chk("add_T5", M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("add_retire", 1'b0);

    // ld
    bus.ir = instr(5'b00000);
    fetch("ld");
    chk("ld_T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    tick();
    chk("ld_T4", M_COUT | M_ZIN, 5'b00011, 1'b1);
    tick();
    chk("ld_T5", M_ZLOOUT | M_MARIN, 5'd0, 1'b1);
    tick();
    chk("ld_T6", M_MEMRD | M_MDRIN, 5'd0, 1'b1);
    tick();
    chk("ld_T7", M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("ld_retire", 1'b0);

    // st
    bus.ir = instr(5'b00010);
    fetch("st");
    chk("st_T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    tick();
    chk("st_T4", M_COUT | M_ZIN, 5'b00011, 1'b1);
    tick();
    chk("st_T5", M_ZLOOUT | M_MARIN, 5'd0, 1'b1);
    tick();
    chk("st_T6", M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
    tick();
    chk("st_T7", M_MEMWR, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("st_retire", 1'b0);

    // mul
    bus.ir = instr(5'b01111);
    fetch("mul");
    chk("mul_T3", M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1);
    tick();
    chk("mul_T4", M_GRB | M_ROUT | M_ZIN, 5'b01111, 1'b1);
    tick();
    chk("mul_T5", M_ZLOOUT | M_LOIN, 5'd0, 1'b1);
    tick();
    chk("mul_T6", M_ZHIOUT | M_HIIN, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("mul_retire", 1'b0);

    // addi
    bus.ir = instr(5'b01100);
    fetch("addi");
    chk("addi_T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    tick();
    chk("addi_T4", M_COUT | M_ZIN, 5'b00011, 1'b1);
    tick();
    chk("addi_T5", M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    chk_stat("addi_retire", 1'b0);

    // undefined opcode behaves as nop and sets the sticky flag on the T3 edge
    bus.ir = instr(5'b11111);
    fetch("ill");
    chk("ill_T3", 25'd0, 5'd0, 1'b1);
    chk_stat("ill_T3_stat", 1'b0);
    tick();
    exp_cnt++;
    chk_stat("ill_retire", 1'b1);

    // halt
    bus.ir = instr(5'b11011);
    fetch("halt");
    chk("halt_T3", 25'd0, 5'd0, 1'b1);
    tick();
    exp_cnt++;
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", 25'd0, 5'd0, 1'b0);
      chk_stat("halt_hold_stat", 1'b1);
      tick();
    end

    // clear out of HALT
    clear = 1'b1;
    tick();
    exp_cnt = 0;
    chk("halt_clear", 25'd0, 5'd0, 1'b0);
    chk_stat("halt_clear_stat", 1'b0);
    clear = 1'b0;
    tick();

    // ld aborted by clear in T5
    bus.ir = instr(5'b00000);
    fetch("ldc");
    tick();
    tick();
    chk("ldc_T5", M_ZLOOUT | M_MARIN, 5'd0, 1'b1);
    clear = 1'b1;
    tick();
    chk("ldc_rst", 25'd0, 5'd0, 1'b0);
    chk_stat("ldc_rst_stat", 1'b0);
    clear = 1'b0;
    tick();
    chk("ldc_T0", M_PCOUT | M_MARIN | M_ZIN, 5'b11111, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
